// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: peripheral address map and 7-segment decode shared by the bridge
package bus_bridge_pkg;
    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;
    localparam logic [11:0] OFF_DIG     = 12'h000;
    localparam logic [11:0] OFF_TMR_VAL = 12'h020;
    localparam logic [11:0] OFF_TMR_DIV = 12'h024;
    localparam logic [11:0] OFF_LED     = 12'h060;
    localparam logic [11:0] OFF_SW      = 12'h070;
    localparam logic [11:0] OFF_BTN     = 12'h078;
    localparam logic [127:0] SEG_TBL = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    function automatic logic [7:0] seg_decode(input logic [3:0] h);
        return SEG_TBL[8*h +: 8];
    endfunction
endpackage

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexes eight hex digits onto an active-low 7-segment display
module seg_scan import bus_bridge_pkg::*; #(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    logic [SW-1:0] slot;
    logic [2:0]    idx;
    always_ff @(posedge cpu_clk or negedge cpu_rst)
        if (!cpu_rst) begin
            slot <= '0;
            idx  <= '0;
        end else if (slot == SW'(SCAN_DIV - 1)) begin
            slot <= '0;
            idx  <= idx + 3'd1;
        end else
            slot <= slot + 1'b1;
    always_comb begin
        dig_en  = ~(8'd1 << idx);
        dig_seg = seg_decode(dig[4*idx +: 4]);
    end
endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: decodes CPU data-bus accesses to data RAM or memory-mapped peripherals
module bus_bridge import bus_bridge_pkg::*; #(
    parameter int          DRAM_AW     = 14,
    parameter int          SCAN_DIV    = 20000,
    parameter logic [31:0] TMR_DIV_RST = 32'd25000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);
    logic        periph, wr, tick;
    logic [11:0] off;
    logic [23:0] sw_meta, sw_sync;
    logic [4:0]  btn_meta, btn_sync;
    logic [31:0] dig, tmr_val, tmr_div, tmr_pre;
    assign periph     = Bus_addr[31:12] == PERIPH_BASE;
    assign off        = Bus_addr[11:0];
    assign wr         = Bus_wen & periph;
    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = Bus_wen & ~periph;
    assign dram_wdata = Bus_wdata;
    // a divider of 0 wraps every cycle, same as 1
    assign tick = tmr_pre == ((tmr_div == '0) ? 32'd0 : tmr_div - 32'd1);
    always_ff @(posedge cpu_clk or negedge cpu_rst)
        if (!cpu_rst) begin
            {sw_sync, sw_meta}   <= '0;
            {btn_sync, btn_meta} <= '0;
        end else begin
            {sw_sync, sw_meta}   <= {sw_meta, sw};
            {btn_sync, btn_meta} <= {btn_meta, btn};
        end
    always_ff @(posedge cpu_clk or negedge cpu_rst)
        if (!cpu_rst) begin
            led <= '0;
            dig <= '0;
        end else begin
            led <= (wr && off == OFF_LED) ? Bus_wdata[23:0] : led;
            dig <= (wr && off == OFF_DIG) ? Bus_wdata : dig;
        end
    always_ff @(posedge cpu_clk or negedge cpu_rst)
        if (!cpu_rst) begin
            tmr_val <= '0;
            tmr_div <= TMR_DIV_RST;
            tmr_pre <= '0;
        end else begin
            tmr_val <= (wr && off == OFF_TMR_VAL) ? Bus_wdata : tmr_val + {31'd0, tick};
            if (wr && off == OFF_TMR_DIV) begin
                tmr_div <= Bus_wdata;
                tmr_pre <= '0;
            end else
                tmr_pre <= tick ? '0 : tmr_pre + 32'd1;
        end
    always_comb
        Bus_rdata = !periph              ? dram_rdata :
                    off == OFF_DIG       ? dig :
                    off == OFF_TMR_VAL   ? tmr_val :
                    off == OFF_TMR_DIV   ? tmr_div :
                    off == OFF_LED       ? {8'd0, led} :
                    off == OFF_SW        ? {8'd0, sw_sync} :
                    off == OFF_BTN       ? {27'd0, btn_sync} : 32'd0;
    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dig     (dig),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );
endmodule

// File: tb/tb_bus_bridge.sv
// tb_bus_bridge: directed and randomized bus traffic against a behavioural bridge model
module tb_bus_bridge;
    logic        cpu_clk, cpu_rst, Bus_wen, dram_we;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata, dram_wdata, dram_rdata;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [4:0]  btn;
    logic [7:0]  dig_en, dig_seg;
    int n_cmp = 0, n_bad = 0;
    bit run = 0;

    bus_bridge #(.DRAM_AW(14), .SCAN_DIV(4), .TMR_DIV_RST(32'd25000)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen),
        .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata), .dram_addr(dram_addr), .dram_we(dram_we),
        .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .sw(sw), .btn(btn), .led(led),
        .dig_en(dig_en), .dig_seg(dig_seg)
    );

    initial cpu_clk = 0;
    always #5 cpu_clk = ~cpu_clk;

    logic [31:0] mem [0:16383];
    assign dram_rdata = mem[dram_addr];

    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // model state: timer kept as cycles since the prescaler was last cleared
    logic [23:0] m_led, sw_p1, sw_p2;
    logic [4:0]  btn_p1, btn_p2;
    logic [31:0] m_dig, m_val, m_div;
    longint      m_c, m_sc;

    function automatic bit m_tick();
        longint e = (m_div == 0) ? 1 : longint'(m_div);
        return (m_c % e) == e - 1;
    endfunction

    function automatic bit is_per(input logic [31:0] a);
        return a[31:12] == 20'hFFFFF;
    endfunction

    always @(posedge cpu_clk or negedge cpu_rst)
        if (!cpu_rst) begin
            m_led <= 0; m_dig <= 0; m_val <= 0; m_div <= 25000; m_c <= 0; m_sc <= 0;
            sw_p1 <= 0; sw_p2 <= 0; btn_p1 <= 0; btn_p2 <= 0;
        end else begin
            if (Bus_wen && !is_per(Bus_addr)) mem[Bus_addr[15:2]] <= Bus_wdata;
            if (Bus_wen && is_per(Bus_addr) && Bus_addr[11:0] == 12'h000) m_dig <= Bus_wdata;
            if (Bus_wen && is_per(Bus_addr) && Bus_addr[11:0] == 12'h060) m_led <= Bus_wdata[23:0];
            if (Bus_wen && is_per(Bus_addr) && Bus_addr[11:0] == 12'h020) m_val <= Bus_wdata;
            else if (m_tick()) m_val <= m_val + 1;
            if (Bus_wen && is_per(Bus_addr) && Bus_addr[11:0] == 12'h024) begin
                m_div <= Bus_wdata;
                m_c <= 0;
            end else m_c <= m_c + 1;
            sw_p1 <= sw; sw_p2 <= sw_p1; btn_p1 <= btn; btn_p2 <= btn_p1;
            m_sc <= m_sc + 1;
        end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (!is_per(a)) return mem[a[15:2]];
        case (a[11:0])
            12'h000: return m_dig;
            12'h020: return m_val;
            12'h024: return m_div;
            12'h060: return {8'h0, m_led};
            12'h070: return {8'h0, sw_p2};
            12'h078: return {27'h0, btn_p2};
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int sidx;
    logic [7:0] e_en, e_seg;
    always @(negedge cpu_clk) if (run) begin
        sidx  = int'((m_sc / 4) % 8);
        e_en  = ~(8'd1 << sidx);
        e_seg = SEG[m_dig[4*sidx +: 4]];
        chk("rdata", Bus_rdata, exp_rd(Bus_addr));
        chk("dram_we", {31'd0, dram_we}, {31'd0, Bus_wen && !is_per(Bus_addr)});
        chk("dram_addr", {18'd0, dram_addr}, {18'd0, Bus_addr[15:2]});
        chk("dram_wdata", dram_wdata, Bus_wdata);
        chk("led", {8'd0, led}, {8'd0, m_led});
        chk("dig_en", {24'd0, dig_en}, {24'd0, e_en});
        chk("dig_seg", {24'd0, dig_seg}, {24'd0, e_seg});
    end

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        Bus_addr = a; Bus_wen = w; Bus_wdata = d;
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(posedge cpu_clk); #1;
        drive(a, w, d);
        @(negedge cpu_clk);
    endtask

    localparam logic [7:0] EN_SEQ [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    localparam logic [7:0] SG_SEQ [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'hC0};
    logic [11:0] offs [6] = '{12'h000, 12'h020, 12'h024, 12'h060, 12'h070, 12'h078};
    logic [31:0] ra, rd;
    int k, rc;
    bit found;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        cpu_rst = 0; sw = 0; btn = 0;
        drive(0, 0, 0);
        repeat (3) @(posedge cpu_clk);
        #1 cpu_rst = 1;
        run = 1;
        @(negedge cpu_clk);
        chk("rst_dig_en", {24'd0, dig_en}, 32'hFE);
        chk("rst_dig_seg", {24'd0, dig_seg}, 32'hC0);

        cyc(32'h0000_0100, 1, 32'hDEADBEEF);
        chk("dram_we_wr", {31'd0, dram_we}, 1);
        chk("dram_addr_wr", {18'd0, dram_addr}, 32'h40);
        cyc(32'h0000_0100, 0, 0);
        chk("dram_we_idle", {31'd0, dram_we}, 0);
        chk("dram_rd", Bus_rdata, 32'hDEADBEEF);
        cyc(32'hFFFF_F060, 1, 32'h0000BEEF);
        chk("led_dram_we", {31'd0, dram_we}, 0);
        cyc(32'hFFFF_F060, 0, 0);
        chk("led_val", {8'd0, led}, 32'hBEEF);
        chk("led_rd", Bus_rdata, 32'hBEEF);

        repeat (3) cyc(32'hFFFF_F070, 0, 0);
        @(posedge cpu_clk); #1;
        sw = 24'h00A5F0;
        @(negedge cpu_clk);
        chk("sw_0edge", Bus_rdata, 0);
        cyc(32'hFFFF_F070, 0, 0);
        chk("sw_1edge", Bus_rdata, 0);
        cyc(32'hFFFF_F070, 0, 0);
        chk("sw_2edge", Bus_rdata, 32'h0000A5F0);
        cyc(32'hFFFF_F040, 0, 0);
        chk("unmapped_rd", Bus_rdata, 0);

        cyc(32'hFFFF_F020, 1, 0);
        cyc(32'hFFFF_F024, 1, 3);
        for (int i = 1; i <= 10; i++) begin
            cyc(32'hFFFF_F020, 0, 0);
            if (i == 9) chk("tmr_div3_8", Bus_rdata, 2);
            if (i == 10) chk("tmr_div3_9", Bus_rdata, 3);
        end
        cyc(32'hFFFF_F024, 1, 0);
        cyc(32'hFFFF_F020, 1, 32'hFFFFFFFF);
        cyc(32'hFFFF_F020, 0, 0);
        chk("tmr_load_wins", Bus_rdata, 32'hFFFFFFFF);
        cyc(32'hFFFF_F020, 0, 0);
        chk("tmr_wrap", Bus_rdata, 0);
        cyc(32'hFFFF_F020, 0, 0);
        chk("tmr_div0_inc", Bus_rdata, 1);

        cyc(32'hFFFF_F000, 1, 32'h76543210);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(32'hFFFF_F000, 0, 0);
            found = (dig_en == 8'hFD);
        end
        chk("scan_found", {31'd0, found}, 1);
        for (int j = 0; j < 8; j++) begin
            chk("scan_en", {24'd0, dig_en}, {24'd0, EN_SEQ[j]});
            chk("scan_seg", {24'd0, dig_seg}, {24'd0, SG_SEQ[j]});
            repeat (4) cyc(32'hFFFF_F000, 0, 0);
        end

        cyc(32'hFFFF_F060, 1, 32'h123);
        #2 cpu_rst = 0;
        #1;
        chk("rst_led", {8'd0, led}, 0);
        chk("rst_en", {24'd0, dig_en}, 32'hFE);
        chk("rst_seg", {24'd0, dig_seg}, 32'hC0);
        cyc(32'hFFFF_F024, 0, 0);
        chk("rst_div", Bus_rdata, 32'd25000);
        chk("rst_led_drop", {8'd0, led}, 0);
        cyc(32'hFFFF_F020, 0, 0);
        chk("rst_val", Bus_rdata, 0);
        #2 cpu_rst = 1;

        rc = 0;
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            if (k < 3) begin
                ra = $urandom;
                if (ra[31:12] == 20'hFFFFF) ra[31] = 1'b0;
            end else ra = {20'hFFFFF, (k == 9) ? 12'($urandom_range(0, 4095)) : offs[k-3]};
            rd = (ra[11:0] == 12'h024) ? $urandom_range(0, 5) : $urandom;
            @(posedge cpu_clk); #1;
            if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
            if ($urandom_range(0, 3) == 0) btn = 5'($urandom);
            drive(ra, $urandom_range(0, 2) == 0, rd);
            @(negedge cpu_clk); #2;
            if (rc > 0) begin
                rc--;
                if (rc == 0) cpu_rst = 1;
            end else if ($urandom_range(0, 399) == 0) begin
                cpu_rst = 0;
                rc = 2;
            end
        end
        cpu_rst = 1;
        @(negedge cpu_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
